gba_sound_dsfifo: RTL and testbench
===================================

Name: gba_sound_dsfifo

Overview:
- One GBA Direct Sound channel FIFO (FIFO A or FIFO B); the sound block instantiates two.
- Sits directly downstream of the timer block: consumes timer0_tick/timer1_tick, pops one signed 8-bit PCM sample per selected tick, and presents it to the sound mixer.
- Filled by CPU/DMA word/halfword writes to the FIFO register; raises a DMA request when the fill level drops to the refill threshold.

Parameters:
- DEPTH_BYTES, 32, FIFO capacity in bytes; power of two.
- DMA_THRESH, 16, DMA is requested when level after a pop is <= this value.

Ports:
- clk  input  1  system clock (16 MHz domain shared with timers).
- reset  input  1  synchronous, active-high reset.
- gb_on  input  1  core enable; when low, ticks and writes are ignored and state is held.
- timer0_tick  input  1  one-cycle overflow pulse from timer 0.
- timer1_tick  input  1  one-cycle overflow pulse from timer 1.
- timer_sel  input  1  SOUNDCNT_H timer select for this channel: 0 = timer0, 1 = timer1.
- fifo_clear  input  1  one-cycle pulse from the SOUNDCNT_H FIFO-reset bit write.
- fifo_we  input  1  one-cycle write strobe for the FIFO register.
- fifo_din  input  32  write data, little-endian byte lanes.
- fifo_be  input  4  byte enables for fifo_din.
- sample_out  output  8  current signed PCM sample, held between pops.
- sample_valid  output  1  one-cycle pulse when sample_out is updated by a pop.
- dma_req  output  1  one-cycle DMA sound request pulse.
- level  output  6  bytes currently stored (0..32).
- overflow  output  1  sticky: a write was dropped for lack of space.
- underflow  output  1  sticky: a tick arrived while the FIFO was empty.

Behaviour:
- Reset is synchronous and active-high. On reset: pointers, level, sample_out, sample_valid, dma_req, overflow, underflow = 0; dma_pending = 0.
- Storage: DEPTH_BYTES x 8-bit array; 5-bit write/read pointers wrap modulo 32; 6-bit level.
- Push:
  - On fifo_we, n = popcount(fifo_be).
  - Enabled lanes are written in ascending lane order (lane 0 first) at consecutive pointer positions.
  - level updates in cycle N+1 after a write in cycle N.
  - Space check: if level_after_pop + n > DEPTH_BYTES, the whole write is dropped and overflow is set. Nothing is partially written.
- Pop:
  - tick = timer_sel ? timer1_tick : timer0_tick.
  - On tick with level > 0: sample_out <= mem[rd]; rd++; level--; sample_valid pulses in cycle N+1.
  - On tick with level = 0: sample_out holds its last value; no sample_valid; underflow is set.
- Simultaneous push and pop in the same cycle:
  - Both apply; level' = level + n - 1.
  - The pop uses pre-write contents, so a push into an empty FIFO cannot be popped in the same cycle (underflow is set).
  - The space check uses the post-pop level, so a full FIFO plus tick plus 1-byte write is accepted.
- DMA request:
  - dma_req pulses in cycle N+1 when a pop in cycle N leaves level' <= DMA_THRESH and dma_pending = 0; dma_pending is then set.
  - dma_pending clears when a write makes level' > DMA_THRESH, or on fifo_clear.
  - Result: at most one request per refill burst (a burst is 4 words).
- fifo_clear:
  - Highest priority: pointers, level, sample_out, dma_pending, overflow and underflow go to 0.
  - A write or tick in the same cycle is ignored.
  - No dma_req or sample_valid is generated in that cycle.
- gb_on = 0: all state is frozen and output pulses are 0. reset and fifo_clear still act.
- Reset mid-operation, in the same cycle as a tick or write: reset wins and nothing is stored.
- Timer select change takes effect on the next cycle's tick mux.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package gba_sound_pkg holds:
  - DSFIFO_DEPTH = 32 and DSFIFO_DMA_THRESH = 16.
  - SOUNDCNT_H bit indices: A timer select 10, A reset 11, B timer select 14, B reset 15.
  - FIFO_A/FIFO_B addresses (0x0A0 / 0x0A4).
- One natural sub-module: gba_dsfifo_lanepack, combinational byte-lane compaction of fifo_din/fifo_be into up to 4 ordered bytes plus count n.
- Pointer/level/DMA logic stays in the top module.

Test Plan:
- Write 0x04030201 (be=1111), then 4 timer0 ticks with timer_sel=0 -> sample_out 0x01,0x02,0x03,0x04 each with a sample_valid pulse; level 4->0.
- Fill with 8 words (level=32), then a 9th word -> write dropped, overflow=1, level stays 32; then tick plus 1-byte write (be=0001) in the same cycle -> accepted, level stays 32.
- From level 32, pop 16 times with timer1 ticks and timer_sel=1 -> single dma_req pulse one cycle after the 16th pop (level=16); the 17th pop gives no further dma_req until 4 words are written (level 19) and level again falls to 16.
- Tick on empty FIFO after sample 0x7F -> sample_out stays 0x7F, no sample_valid, underflow=1; halfword write be=1100 data 0xBBAA0000 -> pushes 0xAA then 0xBB.
- fifo_clear asserted in the same cycle as a tick and a write at level 10 -> level 0, sample_out 0, no sample_valid or dma_req; timer0_tick with timer_sel=1 -> ignored.
- reset held one cycle mid-stream with gb_on=1 -> all outputs 0 the next cycle; gb_on=0 with ticks/writes -> level and sample_out unchanged.

Source files
------------

// File: rtl/gba_sound_pkg.sv
// Shared constants and types for the GBA sound block.
// - Direct Sound FIFO depth and DMA refill threshold.
// - SOUNDCNT_H bit positions for the per-channel timer select and FIFO reset.
// - FIFO_A / FIFO_B register addresses.
// - Byte-lane bundle type used between the lane packer and the FIFO.
package gba_sound_pkg;

  localparam int DSFIFO_DEPTH      = 32;
  localparam int DSFIFO_DMA_THRESH = 16;

  localparam int SOUNDCNT_H_A_TIMER = 10;
  localparam int SOUNDCNT_H_A_RESET = 11;
  localparam int SOUNDCNT_H_B_TIMER = 14;
  localparam int SOUNDCNT_H_B_RESET = 15;

  localparam logic [11:0] FIFO_A_ADDR = 12'h0A0;
  localparam logic [11:0] FIFO_B_ADDR = 12'h0A4;

  // Up to four compacted bytes; entry 0 is the first byte to enter the FIFO.
  typedef logic [3:0][7:0] lane_bytes_t;

endpackage

// File: rtl/gba_dsfifo_lanepack.sv
// Byte-lane compaction for FIFO register writes.
// Ports:
//   fifo_din   in  32  write data, little-endian byte lanes
//   fifo_be    in  4   byte enables
//   lane_bytes out 4x8 enabled bytes, ascending lane order, packed from entry 0
//   lane_cnt   out 3   number of enabled lanes (0..4)
// Purely combinational.
module gba_dsfifo_lanepack
  import gba_sound_pkg::*;
(
  input  logic [31:0] fifo_din,
  input  logic [3:0]  fifo_be,
  output lane_bytes_t lane_bytes,
  output logic [2:0]  lane_cnt
);

  always_comb begin
    lane_bytes = '0;
    lane_cnt   = '0;
    for (int i = 0; i < 4; i++) begin
      if (fifo_be[i]) begin
        lane_bytes[lane_cnt[1:0]] = fifo_din[8*i +: 8];
        lane_cnt = lane_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/gba_sound_dsfifo.sv
// One GBA Direct Sound channel FIFO (A or B).
// Bytes are pushed by CPU/DMA writes to the FIFO register and popped one per
// selected timer overflow; the popped byte is held on sample_out for the mixer.
// A single DMA request is raised each time a pop brings the level down to the
// refill threshold.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   gb_on                 core enable; low freezes state (reset/fifo_clear still act)
//   timer0_tick/1_tick    one-cycle timer overflow pulses
//   timer_sel             0 = timer0, 1 = timer1
//   fifo_clear            one-cycle FIFO reset pulse, highest priority
//   fifo_we/din/be        FIFO register write strobe, data, byte enables
//   sample_out            current signed 8-bit sample
//   sample_valid          pulse when sample_out was updated by a pop
//   dma_req               one-cycle DMA sound request
//   level                 bytes stored (0..32)
//   overflow/underflow    sticky error flags
module gba_sound_dsfifo
  import gba_sound_pkg::*;
#(
  parameter int DEPTH_BYTES = DSFIFO_DEPTH,
  parameter int DMA_THRESH  = DSFIFO_DMA_THRESH
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        gb_on,
  input  logic        timer0_tick,
  input  logic        timer1_tick,
  input  logic        timer_sel,
  input  logic        fifo_clear,
  input  logic        fifo_we,
  input  logic [31:0] fifo_din,
  input  logic [3:0]  fifo_be,
  output logic [7:0]  sample_out,
  output logic        sample_valid,
  output logic        dma_req,
  output logic [5:0]  level,
  output logic        overflow,
  output logic        underflow
);

  localparam int         PTR_W    = $clog2(DEPTH_BYTES);
  localparam logic [6:0] DEPTH_L  = 7'(DEPTH_BYTES);
  localparam logic [6:0] THRESH_L = 7'(DMA_THRESH);

  lane_bytes_t lane_bytes;
  logic [2:0]  lane_cnt;

  gba_dsfifo_lanepack u_lanepack (
    .fifo_din   (fifo_din),
    .fifo_be    (fifo_be),
    .lane_bytes (lane_bytes),
    .lane_cnt   (lane_cnt)
  );

  logic [7:0]       mem_q [DEPTH_BYTES];
  logic [7:0]       mem_d [DEPTH_BYTES];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [5:0]       level_q, level_d;
  logic [7:0]       sample_out_q, sample_out_d;
  logic             sample_valid_q, sample_valid_d;
  logic             dma_req_q, dma_req_d;
  logic             dma_pending_q, dma_pending_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             tick;
  logic             write;
  logic             pop;
  logic             push_ok;
  logic [6:0]       lvl_after_pop;
  logic [6:0]       lvl_after_push;
  logic [6:0]       lvl_final;

  always_comb begin
    mem_d          = mem_q;
    wr_d           = wr_q;
    rd_d           = rd_q;
    level_d        = level_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    dma_req_d      = 1'b0;
    dma_pending_d  = dma_pending_q;
    overflow_d     = overflow_q;
    underflow_d    = underflow_q;

    tick  = gb_on & (timer_sel ? timer1_tick : timer0_tick);
    write = gb_on & fifo_we;
    pop   = tick & (level_q != 6'd0);

    // Space is judged after this cycle's pop, so a full FIFO can take one
    // byte in the same cycle a sample leaves.
    lvl_after_pop  = {1'b0, level_q} - {6'd0, pop};
    lvl_after_push = lvl_after_pop + {4'd0, lane_cnt};
    push_ok        = write & (lvl_after_push <= DEPTH_L);
    lvl_final      = push_ok ? lvl_after_push : lvl_after_pop;

    if (fifo_clear) begin
      wr_d          = '0;
      rd_d          = '0;
      level_d       = '0;
      sample_out_d  = '0;
      dma_pending_d = 1'b0;
      overflow_d    = 1'b0;
      underflow_d   = 1'b0;
    end else begin
      if (tick & ~pop) underflow_d = 1'b1;
      if (write & ~push_ok) overflow_d = 1'b1;

      // Pop reads the pre-write array contents.
      if (pop) begin
        sample_out_d   = mem_q[rd_q];
        sample_valid_d = 1'b1;
        rd_d           = rd_q + PTR_W'(1);
      end

      if (push_ok) begin
        for (int i = 0; i < 4; i++) begin
          if (3'(i) < lane_cnt) mem_d[wr_q + PTR_W'(i)] = lane_bytes[2'(i)];
        end
        wr_d = wr_q + PTR_W'(lane_cnt);
      end

      level_d = lvl_final[5:0];

      // One request per refill: armed again only once writes lift the level
      // back above the threshold.
      if (pop && (lvl_final <= THRESH_L) && !dma_pending_q) begin
        dma_req_d     = 1'b1;
        dma_pending_d = 1'b1;
      end else if (push_ok && (lvl_final > THRESH_L)) begin
        dma_pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q           <= '0;
      rd_q           <= '0;
      level_q        <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      dma_req_q      <= 1'b0;
      dma_pending_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_q           <= wr_d;
      rd_q           <= rd_d;
      level_q        <= level_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      dma_req_q      <= dma_req_d;
      dma_pending_q  <= dma_pending_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage needs no reset; a write coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (!reset) mem_q <= mem_d;
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign dma_req      = dma_req_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_gba_sound_dsfifo.sv
module tb_gba_sound_dsfifo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        gb_on = 1'b1;
  logic        timer0_tick = 1'b0;
  logic        timer1_tick = 1'b0;
  logic        timer_sel = 1'b0;
  logic        fifo_clear = 1'b0;
  logic        fifo_we = 1'b0;
  logic [31:0] fifo_din = '0;
  logic [3:0]  fifo_be = '0;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        dma_req;
  logic [5:0]  level;
  logic        overflow;
  logic        underflow;

  int total = 0;
  int bad = 0;

  gba_sound_dsfifo dut (
    .clk          (clk),
    .reset        (reset),
    .gb_on        (gb_on),
    .timer0_tick  (timer0_tick),
    .timer1_tick  (timer1_tick),
    .timer_sel    (timer_sel),
    .fifo_clear   (fifo_clear),
    .fifo_we      (fifo_we),
    .fifo_din     (fifo_din),
    .fifo_be      (fifo_be),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .dma_req      (dma_req),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Advance one clock, sample 1 time unit after the edge, drop pulse inputs.
  task automatic step();
    @(posedge clk);
    #1;
    timer0_tick = 1'b0;
    timer1_tick = 1'b0;
    fifo_we     = 1'b0;
    fifo_clear  = 1'b0;
    reset       = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d, input logic [3:0] be);
    fifo_we  = 1'b1;
    fifo_din = d;
    fifo_be  = be;
    step();
  endtask

  task automatic tk(input logic use_t1);
    if (use_t1) timer1_tick = 1'b1;
    else        timer0_tick = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    total++; if (level !== 6'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (sample_out !== 8'h00) begin bad++; $display("FAIL reset_sample got=%h exp=00", sample_out); end
    total++; if ({sample_valid, dma_req, overflow, underflow} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {sample_valid, dma_req, overflow, underflow});
    end
  endtask

  task automatic test_basic();
    timer_sel = 1'b0;
    wr(32'h04030201, 4'b1111);
    total++; if (level !== 6'd4) begin bad++; $display("FAIL basic_level got=%0d exp=4", level); end
    for (int k = 0; k < 4; k++) begin
      tk(1'b0);
      total++; if (sample_out !== 8'(k + 1)) begin bad++; $display("FAIL basic_sample%0d got=%h exp=%h", k, sample_out, 8'(k + 1)); end
      total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL basic_valid%0d got=%b exp=1", k, sample_valid); end
      total++; if (level !== 6'(3 - k)) begin bad++; $display("FAIL basic_lvl%0d got=%0d exp=%0d", k, level, 3 - k); end
      // First pop leaves level 3 with no request outstanding.
      total++; if (dma_req !== (k == 0)) begin bad++; $display("FAIL basic_dma%0d got=%b exp=%b", k, dma_req, k == 0); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    for (int k = 0; k < 8; k++) begin
      w = {8'(8'h23 + 4*k), 8'(8'h22 + 4*k), 8'(8'h21 + 4*k), 8'(8'h20 + 4*k)};
      wr(w, 4'b1111);
    end
    total++; if (level !== 6'd32) begin bad++; $display("FAIL ovf_full_level got=%0d exp=32", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow); end
    wr(32'hDEADBEEF, 4'b1111);
    total++; if (level !== 6'd32) begin bad++; $display("FAIL ovf_drop_level got=%0d exp=32", level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    // Full FIFO + tick + one-byte write in the same cycle: accepted.
    timer0_tick = 1'b1;
    wr(32'h00000099, 4'b0001);
    total++; if (level !== 6'd32) begin bad++; $display("FAIL ovf_tickwr_level got=%0d exp=32", level); end
    total++; if (sample_out !== 8'h20 || sample_valid !== 1'b1) begin
      bad++; $display("FAIL ovf_tickwr_sample got=%h/%b exp=20/1", sample_out, sample_valid);
    end
  endtask

  task automatic test_dma();
    int reqs;
    timer_sel = 1'b1;
    reqs = 0;
    for (int k = 1; k <= 16; k++) begin
      tk(1'b1);
      total++; if (sample_out !== 8'(8'h20 + k)) begin bad++; $display("FAIL dma_sample%0d got=%h exp=%h", k, sample_out, 8'(8'h20 + k)); end
      total++; if (dma_req !== (k == 16)) begin bad++; $display("FAIL dma_req_pop%0d got=%b exp=%b", k, dma_req, k == 16); end
      if (dma_req === 1'b1) reqs++;
    end
    total++; if (reqs != 1) begin bad++; $display("FAIL dma_req_count got=%0d exp=1", reqs); end
    total++; if (level !== 6'd16) begin bad++; $display("FAIL dma_level16 got=%0d exp=16", level); end
    tk(1'b1);
    total++; if (dma_req !== 1'b0 || level !== 6'd15) begin
      bad++; $display("FAIL dma_pop17 got=%b/%0d exp=0/15", dma_req, level);
    end
    wr(32'h44434241, 4'b1111);
    total++; if (level !== 6'd19) begin bad++; $display("FAIL dma_refill_level got=%0d exp=19", level); end
    for (int k = 0; k < 3; k++) begin
      tk(1'b1);
      total++; if (dma_req !== (k == 2)) begin bad++; $display("FAIL dma_rearm%0d got=%b exp=%b", k, dma_req, k == 2); end
    end
    total++; if (level !== 6'd16) begin bad++; $display("FAIL dma_rearm_level got=%0d exp=16", level); end
  endtask

  task automatic test_underflow();
    fifo_clear = 1'b1;
    step();
    total++; if (level !== 6'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL uf_clear got=%0d/%b exp=0/0", level, overflow);
    end
    timer_sel = 1'b0;
    wr(32'h0000007F, 4'b0001);
    tk(1'b0);
    total++; if (sample_out !== 8'h7F || sample_valid !== 1'b1) begin
      bad++; $display("FAIL uf_sample7f got=%h/%b exp=7f/1", sample_out, sample_valid);
    end
    tk(1'b0);
    total++; if (sample_out !== 8'h7F) begin bad++; $display("FAIL uf_hold got=%h exp=7f", sample_out); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL uf_valid got=%b exp=0", sample_valid); end
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_flag got=%b exp=1", underflow); end
    wr(32'hBBAA0000, 4'b1100);
    total++; if (level !== 6'd2) begin bad++; $display("FAIL uf_half_level got=%0d exp=2", level); end
    tk(1'b0);
    total++; if (sample_out !== 8'hAA) begin bad++; $display("FAIL uf_half0 got=%h exp=aa", sample_out); end
    tk(1'b0);
    total++; if (sample_out !== 8'hBB) begin bad++; $display("FAIL uf_half1 got=%h exp=bb", sample_out); end
  endtask

  task automatic test_clear();
    timer_sel = 1'b1;
    wr(32'h11111111, 4'b1111);
    wr(32'h22222222, 4'b1111);
    wr(32'h00003333, 4'b0011);
    total++; if (level !== 6'd10) begin bad++; $display("FAIL clr_pre_level got=%0d exp=10", level); end
    fifo_clear  = 1'b1;
    timer1_tick = 1'b1;
    wr(32'h55555555, 4'b1111);
    total++; if (level !== 6'd0) begin bad++; $display("FAIL clr_level got=%0d exp=0", level); end
    total++; if (sample_out !== 8'h00) begin bad++; $display("FAIL clr_sample got=%h exp=00", sample_out); end
    total++; if (sample_valid !== 1'b0 || dma_req !== 1'b0) begin
      bad++; $display("FAIL clr_pulses got=%b/%b exp=0/0", sample_valid, dma_req);
    end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL clr_uf got=%b exp=0", underflow); end
    wr(32'h66666666, 4'b1111);
    tk(1'b0);
    total++; if (level !== 6'd4 || sample_valid !== 1'b0) begin
      bad++; $display("FAIL clr_wrong_timer got=%0d/%b exp=4/0", level, sample_valid);
    end
  endtask

  task automatic test_reset_mid();
    reset       = 1'b1;
    timer1_tick = 1'b1;
    wr(32'h77777777, 4'b1111);
    total++; if (level !== 6'd0 || sample_out !== 8'h00) begin
      bad++; $display("FAIL rmid_state got=%0d/%h exp=0/00", level, sample_out);
    end
    total++; if ({sample_valid, dma_req, overflow, underflow} !== 4'b0000) begin
      bad++; $display("FAIL rmid_flags got=%b exp=0000", {sample_valid, dma_req, overflow, underflow});
    end
    timer_sel = 1'b0;
    wr(32'h0D0C0B0A, 4'b1111);
    tk(1'b0);
    total++; if (sample_out !== 8'h0A || level !== 6'd3) begin
      bad++; $display("FAIL rmid_pop got=%h/%0d exp=0a/3", sample_out, level);
    end
    gb_on = 1'b0;
    timer0_tick = 1'b1;
    wr(32'hFFFFFFFF, 4'b1111);
    tk(1'b0);
    total++; if (level !== 6'd3 || sample_out !== 8'h0A) begin
      bad++; $display("FAIL gboff_hold got=%0d/%h exp=3/0a", level, sample_out);
    end
    total++; if (sample_valid !== 1'b0 || dma_req !== 1'b0) begin
      bad++; $display("FAIL gboff_pulses got=%b/%b exp=0/0", sample_valid, dma_req);
    end
    gb_on = 1'b1;
    tk(1'b0);
    total++; if (sample_out !== 8'h0B || level !== 6'd2) begin
      bad++; $display("FAIL gbon_resume got=%h/%0d exp=0b/2", sample_out, level);
    end
  endtask

  initial begin
    step();
    test_reset();
    test_basic();
    test_overflow();
    test_dma();
    test_underflow();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
